// File: rtl/cu_issue_ctrl.sv
// Compute-unit issue/control: two-stage (E/W) instruction pipeline, CU control decode,
// flag capture into astat/sticky, and bus-connect writeback arbitration.
module cu_issue_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned SIGNAL_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  input  logic                     bc_wr_valid,
  output logic                     bc_wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] bc_wr_addr,
  output logic                     ps_alu_en,
  output logic                     ps_alu_log,
  output logic                     ps_alu_sat,
  output logic [1:0]               ps_alu_hc,
  output logic [2:0]               ps_alu_sc,
  output logic                     ps_mul_en,
  output logic                     ps_mul_otreg,
  output logic [3:0]               ps_mul_dtsts,
  output logic [1:0]               ps_mul_cls,
  output logic [1:0]               ps_mul_sc,
  output logic                     ps_shf_en,
  output logic [1:0]               ps_shf_cls,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
  output logic                     ps_xb_w_bcEn,
  input  logic                     alu_ps_az,
  input  logic                     alu_ps_an,
  input  logic                     alu_ps_ac,
  input  logic                     alu_ps_av,
  input  logic                     mul_ps_mv,
  input  logic                     mul_ps_mn,
  input  logic                     shf_ps_sv,
  input  logic                     shf_ps_sz,
  input  logic                     sticky_clr,
  output logic [7:0]               astat,
  output logic [7:0]               sticky
);

  localparam int unsigned FLAG_W = 8;
  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_SHF = 2'd2;

  logic                     e_valid;
  logic [31:0]              e_instr;
  logic                     w_exec;
  logic [1:0]               w_unit;
  logic [ADDRESS_WIDTH-1:0] w_wadd;

  logic [1:0]               e_unit;
  logic [ADDRESS_WIDTH-1:0] e_wadd, e_rx, e_ry;
  logic [3:0]               e_cond;
  logic                     cond_pass, stall, issue, accept;
  logic [FLAG_W-1:0]        flags_in, flag_mask, set_bits;
  logic                     unused_bits;

  assign e_unit      = e_instr[31:30];
  assign e_wadd      = ADDRESS_WIDTH'(e_instr[29:26]);
  assign e_rx        = ADDRESS_WIDTH'(e_instr[25:22]);
  assign e_ry        = ADDRESS_WIDTH'(e_instr[21:18]);
  assign e_cond      = e_instr[8:5];
  assign unused_bits = ^e_instr[4:0];

  // Condition code evaluated against the current astat
  always_comb begin
    cond_pass = 1'b0;
    case (e_cond)
      4'd0:    cond_pass = 1'b1;
      4'd1:    cond_pass = astat[0];
      4'd2:    cond_pass = ~astat[0];
      4'd3:    cond_pass = astat[1];
      4'd4:    cond_pass = ~astat[1];
      4'd5:    cond_pass = astat[2];
      4'd6:    cond_pass = astat[3];
      4'd7:    cond_pass = astat[4];
      4'd8:    cond_pass = astat[5];
      4'd9:    cond_pass = astat[6];
      4'd10:   cond_pass = astat[7];
      default: cond_pass = 1'b0;
    endcase
  end

  // A writing W instruction blocks E on a register hazard or on a not-yet-visible flag update
  assign stall = e_valid & w_exec &
                 ((w_wadd == e_rx) | (w_wadd == e_ry) | (e_cond != 4'd0));
  assign issue       = e_valid & ~stall & cond_pass & (e_unit != 2'd3);
  assign instr_ready = ~e_valid | ~stall;
  assign accept      = instr_valid & instr_ready;
  assign bc_wr_ready = bc_wr_valid & ~w_exec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid <= 1'b0;
      e_instr <= '0;
      w_exec  <= 1'b0;
      w_unit  <= '0;
      w_wadd  <= '0;
    end else begin
      if (!stall) begin
        e_valid <= accept;
        if (accept) e_instr <= instr;
      end
      w_exec <= issue;
      w_unit <= e_unit;
      w_wadd <= e_wadd;
    end
  end

  // Unit controls from E, writeback select from W, bus write fills idle W slots
  always_comb begin
    ps_alu_en    = 1'b0;
    ps_alu_log   = 1'b0;
    ps_alu_sat   = 1'b0;
    ps_alu_hc    = '0;
    ps_alu_sc    = '0;
    ps_mul_en    = 1'b0;
    ps_mul_otreg = 1'b0;
    ps_mul_dtsts = '0;
    ps_mul_cls   = '0;
    ps_mul_sc    = '0;
    ps_shf_en    = 1'b0;
    ps_shf_cls   = '0;
    ps_xb_raddx  = '0;
    ps_xb_raddy  = '0;
    ps_xb_wadd   = '0;
    ps_xb_w_cuEn = '0;
    ps_xb_w_bcEn = 1'b0;
    if (e_valid) begin
      ps_xb_raddx = e_rx;
      ps_xb_raddy = e_ry;
    end
    if (issue) begin
      case (e_unit)
        UNIT_ALU: begin
          ps_alu_en  = 1'b1;
          ps_alu_log = e_instr[17];
          ps_alu_hc  = e_instr[16:15];
          ps_alu_sc  = e_instr[14:12];
          ps_alu_sat = e_instr[11];
        end
        UNIT_MUL: begin
          ps_mul_en    = 1'b1;
          ps_mul_otreg = e_instr[17];
          ps_mul_dtsts = e_instr[16:13];
          ps_mul_cls   = e_instr[12:11];
          ps_mul_sc    = e_instr[10:9];
        end
        UNIT_SHF: begin
          ps_shf_en  = 1'b1;
          ps_shf_cls = e_instr[17:16];
        end
        default: ;
      endcase
    end
    if (w_exec) begin
      ps_xb_w_cuEn = SIGNAL_WIDTH'(1) << w_unit;
      ps_xb_wadd   = w_wadd;
    end else if (bc_wr_valid) begin
      ps_xb_w_bcEn = 1'b1;
      ps_xb_wadd   = bc_wr_addr;
    end
  end

  assign flags_in = {shf_ps_sz, shf_ps_sv, mul_ps_mn, mul_ps_mv,
                     alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};

  always_comb begin
    flag_mask = '0;
    if (w_exec) begin
      case (w_unit)
        UNIT_ALU: flag_mask = 8'h0F;
        UNIT_MUL: flag_mask = 8'h30;
        UNIT_SHF: flag_mask = 8'hC0;
        default:  flag_mask = '0;
      endcase
    end
  end

  assign set_bits = flags_in & flag_mask;

  // Only the writing unit's flags move; a set beats a same-cycle sticky clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      astat  <= '0;
      sticky <= '0;
    end else begin
      astat  <= (astat & ~flag_mask) | set_bits;
      sticky <= (sticky_clr ? 8'h00 : sticky) | set_bits;
    end
  end

endmodule

// File: tb/tb_cu_issue_ctrl.sv
// Self-checking bench for cu_issue_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_cu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic        bc_wr_valid, bc_wr_ready;
  logic [3:0]  bc_wr_addr;
  logic        ps_alu_en, ps_alu_log, ps_alu_sat;
  logic [1:0]  ps_alu_hc;
  logic [2:0]  ps_alu_sc;
  logic        ps_mul_en, ps_mul_otreg;
  logic [3:0]  ps_mul_dtsts;
  logic [1:0]  ps_mul_cls, ps_mul_sc;
  logic        ps_shf_en;
  logic [1:0]  ps_shf_cls;
  logic [3:0]  ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
  logic [2:0]  ps_xb_w_cuEn;
  logic        ps_xb_w_bcEn;
  logic [7:0]  flags;
  logic        sticky_clr;
  logic [7:0]  astat, sticky;
  logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;
  logic        mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz;

  assign {shf_ps_sz, shf_ps_sv, mul_ps_mn, mul_ps_mv,
          alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az} = flags;

  cu_issue_ctrl #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .bc_wr_valid(bc_wr_valid), .bc_wr_ready(bc_wr_ready), .bc_wr_addr(bc_wr_addr),
    .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_sat(ps_alu_sat),
    .ps_alu_hc(ps_alu_hc), .ps_alu_sc(ps_alu_sc),
    .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
    .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
    .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
    .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy), .ps_xb_wadd(ps_xb_wadd),
    .ps_xb_w_cuEn(ps_xb_w_cuEn), .ps_xb_w_bcEn(ps_xb_w_bcEn),
    .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac), .alu_ps_av(alu_ps_av),
    .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn), .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
    .sticky_clr(sticky_clr), .astat(astat), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy, bcr, alu_en, alu_log, alu_sat;
    logic [1:0] alu_hc;
    logic [2:0] alu_sc;
    logic       mul_en, mul_otreg;
    logic [3:0] mul_dtsts;
    logic [1:0] mul_cls, mul_sc;
    logic       shf_en;
    logic [1:0] shf_cls;
    logic [3:0] rx, ry, wadd;
    logic [2:0] cu;
    logic       bc;
    logic [7:0] astat, sticky;
  } out_t;

  typedef struct {
    logic iv; logic [31:0] ins; logic bcv; logic [3:0] bca; logic [7:0] fl; logic clr;
    logic rdy, alu_en, mul_en, shf_en; logic [3:0] rx, ry, wadd; logic [2:0] cu;
    logic bc, bcr; logic [7:0] astat, sticky;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mk(input logic [1:0] u, input logic [3:0] wa,
                                     input logic [3:0] rx, input logic [3:0] ry,
                                     input logic [8:0] ctl, input logic [3:0] cnd);
    return {u, wa, rx, ry, ctl, cnd, 5'b00000};
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = '{rdy: instr_ready, bcr: bc_wr_ready, alu_en: ps_alu_en, alu_log: ps_alu_log,
          alu_sat: ps_alu_sat, alu_hc: ps_alu_hc, alu_sc: ps_alu_sc, mul_en: ps_mul_en,
          mul_otreg: ps_mul_otreg, mul_dtsts: ps_mul_dtsts, mul_cls: ps_mul_cls,
          mul_sc: ps_mul_sc, shf_en: ps_shf_en, shf_cls: ps_shf_cls, rx: ps_xb_raddx,
          ry: ps_xb_raddy, wadd: ps_xb_wadd, cu: ps_xb_w_cuEn, bc: ps_xb_w_bcEn,
          astat: astat, sticky: sticky};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic bcv,
                       input logic [3:0] bca, input logic [7:0] fl, input logic clr);
    instr_valid = iv; instr = ins; bc_wr_valid = bcv; bc_wr_addr = bca;
    flags = fl; sticky_clr = clr;
  endtask

  // Holds reset for two edges with idle inputs, releases it mid-cycle
  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  bit          m_e_v;
  logic [31:0] m_e_ins;
  bit          m_w_wr;
  logic [1:0]  m_w_unit;
  logic [3:0]  m_w_dst;
  logic [7:0]  m_astat, m_sticky;

  function automatic bit cond_holds(input logic [3:0] c, input logic [7:0] a);
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return a[0];
      4'd2:  return !a[0];
      4'd3:  return a[1];
      4'd4:  return !a[1];
      4'd5:  return a[2];
      4'd6:  return a[3];
      4'd7:  return a[4];
      4'd8:  return a[5];
      4'd9:  return a[6];
      4'd10: return a[7];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] unit_flags(input logic [1:0] u);
    case (u)
      2'd0: return 8'b0000_1111;
      2'd1: return 8'b0011_0000;
      2'd2: return 8'b1100_0000;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_e_v = 0; m_e_ins = '0; m_w_wr = 0; m_w_unit = '0; m_w_dst = '0;
    m_astat = '0; m_sticky = '0;
  endtask

  // Predicts this cycle's outputs from the current inputs, then advances one clock
  task automatic model_cycle(output out_t e);
    logic [1:0] u;
    logic [3:0] rx, ry, cnd;
    bit hold, go, take;
    logic [7:0] upd;
    u = m_e_ins[31:30]; rx = m_e_ins[25:22]; ry = m_e_ins[21:18]; cnd = m_e_ins[8:5];
    hold = m_e_v && m_w_wr && (m_w_dst == rx || m_w_dst == ry || cnd != 0);
    go   = m_e_v && !hold && cond_holds(cnd, m_astat) && u != 2'd3;
    e = '0;
    e.rdy = !(m_e_v && hold);
    if (m_e_v) begin e.rx = rx; e.ry = ry; end
    if (go && u == 2'd0) begin
      e.alu_en = 1; e.alu_log = m_e_ins[17]; e.alu_hc = m_e_ins[16:15];
      e.alu_sc = m_e_ins[14:12]; e.alu_sat = m_e_ins[11];
    end
    if (go && u == 2'd1) begin
      e.mul_en = 1; e.mul_otreg = m_e_ins[17]; e.mul_dtsts = m_e_ins[16:13];
      e.mul_cls = m_e_ins[12:11]; e.mul_sc = m_e_ins[10:9];
    end
    if (go && u == 2'd2) begin e.shf_en = 1; e.shf_cls = m_e_ins[17:16]; end
    if (m_w_wr) begin
      e.cu = 3'(1 << m_w_unit); e.wadd = m_w_dst;
    end else if (bc_wr_valid) begin
      e.bcr = 1; e.bc = 1; e.wadd = bc_wr_addr;
    end
    e.astat = m_astat; e.sticky = m_sticky;
    take = instr_valid && e.rdy;
    upd = m_w_wr ? unit_flags(m_w_unit) : 8'h00;
    m_astat  = (m_astat & ~upd) | (flags & upd);
    m_sticky = (sticky_clr ? 8'h00 : m_sticky) | (flags & upd);
    m_w_wr = go; m_w_unit = u; m_w_dst = m_e_ins[29:26];
    if (!hold) begin
      m_e_v = take;
      if (take) m_e_ins = instr;
    end
  endtask

  vec_t tbl[8];
  out_t o, e;
  logic [31:0] ia, ib, ic, id;

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    ia = mk(2'd0, 4'd3, 4'd1, 4'd2, 9'b110101100, 4'd0);
    ib = mk(2'd1, 4'd5, 4'd0, 4'd0, 9'b110101001, 4'd0);
    ic = mk(2'd2, 4'd7, 4'd5, 4'd6, 9'b100000000, 4'd0);
    id = mk(2'd3, 4'd0, 4'd0, 4'd0, 9'b000000000, 4'd0);
    //          iv  ins bcv bca fl     clr rdy alu mul shf rx ry wa cu bc bcr astat  sticky
    tbl[0] = '{1, ia, 0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[1] = '{1, ib, 0, 0, 8'h00, 0,  1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[2] = '{1, ic, 0, 0, 8'h01, 0,  1, 0, 1, 0, 0, 0, 3, 1, 0, 0, 8'h00, 8'h00};
    tbl[3] = '{1, id, 1, 9, 8'h10, 0,  0, 0, 0, 0, 5, 6, 5, 2, 0, 0, 8'h01, 8'h01};
    tbl[4] = '{1, id, 1, 9, 8'h00, 0,  1, 0, 0, 1, 5, 6, 9, 0, 1, 1, 8'h11, 8'h11};
    tbl[5] = '{0, 0,  0, 0, 8'h40, 1,  1, 0, 0, 0, 0, 0, 7, 4, 0, 0, 8'h11, 8'h11};
    tbl[6] = '{0, 0,  0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h51, 8'h40};
    tbl[7] = '{0, 0,  0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h51, 8'h00};

    #3;
    o = dut_out();
    chk("reset_state", 64'({o.alu_en, o.mul_en, o.shf_en, o.cu, o.bc, o.wadd, o.astat, o.sticky}), 64'h0);
    tick();
    reset = 1'b1;

    // Directed table: ALU issue, MUL->SHF hazard stall, bus write deferral, sticky clear
    foreach (tbl[i]) begin
      if (i > 0) tick();
      drive(tbl[i].iv, tbl[i].ins, tbl[i].bcv, tbl[i].bca, tbl[i].fl, tbl[i].clr);
      #1;
      o = dut_out();
      chk($sformatf("vec%0d", i),
          64'({o.rdy, o.alu_en, o.mul_en, o.shf_en, o.rx, o.ry, o.wadd, o.cu, o.bc, o.bcr, o.astat, o.sticky}),
          64'({tbl[i].rdy, tbl[i].alu_en, tbl[i].mul_en, tbl[i].shf_en, tbl[i].rx, tbl[i].ry,
               tbl[i].wadd, tbl[i].cu, tbl[i].bc, tbl[i].bcr, tbl[i].astat, tbl[i].sticky}));
    end
    tick();
    chk("vec_alu_fields", 64'({ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat}), 64'h0);

    // Conditional EQ: skipped while az=0, executes once az=1
    do_reset();
    drive(1'b1, mk(2'd0, 4'd2, 4'd0, 4'd1, 9'd0, 4'd1), 1'b0, '0, '0, 1'b0);
    tick(); drive(1'b0, '0, 1'b0, '0, '0, 1'b0); #1;
    chk("eq_false_en", 64'({ps_alu_en, ps_xb_raddy}), 64'({1'b0, 4'd1}));
    tick(); flags = 8'hFF; #1;
    chk("eq_false_cuen", 64'(ps_xb_w_cuEn), 64'd0);
    tick(); flags = 8'h00; #1;
    chk("eq_false_astat", 64'(astat), 64'd0);
    drive(1'b1, mk(2'd0, 4'd4, 4'd0, 4'd0, 9'd0, 4'd0), 1'b0, '0, '0, 1'b0);
    tick(); drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick(); flags = 8'h01; #1;
    chk("set_az_cuen", 64'({ps_xb_w_cuEn, ps_xb_wadd}), 64'({3'b001, 4'd4}));
    tick(); drive(1'b1, mk(2'd0, 4'd6, 4'd1, 4'd1, 9'd0, 4'd1), 1'b0, '0, '0, 1'b0); #1;
    chk("set_az_astat", 64'(astat), 64'h01);
    tick(); drive(1'b0, '0, 1'b0, '0, '0, 1'b0); #1;
    chk("eq_true_en", 64'(ps_alu_en), 64'd1);
    tick(); #1;
    chk("eq_true_cuen", 64'({ps_xb_w_cuEn, ps_xb_wadd}), 64'({3'b001, 4'd6}));

    // Reset mid-flight: ALU in W, MUL in E
    do_reset();
    drive(1'b1, mk(2'd0, 4'd1, 4'd2, 4'd3, 9'd0, 4'd0), 1'b0, '0, '0, 1'b0);
    tick(); drive(1'b1, mk(2'd1, 4'd8, 4'd0, 4'd0, 9'd0, 4'd0), 1'b0, '0, '0, 1'b0);
    tick(); drive(1'b0, '0, 1'b0, '0, 8'hFF, 1'b0); #1;
    chk("pre_rst_busy", 64'({ps_xb_w_cuEn, ps_mul_en}), 64'({3'b001, 1'b1}));
    reset = 1'b0; #1;
    chk("rst_drop", 64'({ps_xb_w_cuEn, ps_mul_en, ps_alu_en, ps_xb_raddx, ps_xb_wadd, astat}), 64'h0);
    tick(); reset = 1'b1; #1;
    chk("rst_release", 64'({instr_ready, astat, sticky, ps_xb_w_cuEn}), 64'({1'b1, 16'h0, 3'b0}));
    tick(); #1;
    chk("rst_no_update", 64'({astat, sticky}), 64'h0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if (i > 0) tick();
      drive(1'($urandom_range(0, 9) < 7),
            mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 9'($urandom),
               ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15))),
            1'($urandom_range(0, 9) < 3), 4'($urandom), 8'($urandom),
            1'($urandom_range(0, 9) == 0));
      #1;
      o = dut_out();
      model_cycle(e);
      chk($sformatf("rand%0d", i), 64'(o), 64'(e));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
